// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and defaults for the PC / fetch sequencer
package pc_seq_pkg;

    localparam int          PC_SEQ_INSTR_W  = 16;
    localparam logic [15:0] PC_SEQ_RESET_PC = 16'h3000;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        WAIT,
        HOLD,
        DROP
    } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - redirect, instruction-memory and decoder handshake bundle
interface pc_sequencer_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               pc_ctl_0_in;
    logic               pc_ctl_1_in;
    logic [ADDR_W-1:0]  target_in;
    logic               imem_req_out;
    logic [ADDR_W-1:0]  imem_addr_out;
    logic               imem_ready_in;
    logic               imem_valid_in;
    logic [INSTR_W-1:0] imem_data_in;
    logic               instr_valid_out;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc_out;
    logic               instr_ready_in;
    logic               flush_out;

    modport master (
        input  pc_ctl_0_in, pc_ctl_1_in, target_in,
        input  imem_ready_in, imem_valid_in, imem_data_in,
        input  instr_ready_in,
        output imem_req_out, imem_addr_out,
        output instr_valid_out, instr_out, instr_pc_out,
        output flush_out
    );

    modport slave (
        output pc_ctl_0_in, pc_ctl_1_in, target_in,
        output imem_ready_in, imem_valid_in, imem_data_in,
        output instr_ready_in,
        input  imem_req_out, imem_addr_out,
        input  instr_valid_out, instr_out, instr_pc_out,
        input  flush_out
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register and one-outstanding instruction-fetch sequencer
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = PC_SEQ_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_SEQ_RESET_PC)
) (
    input  logic            clka,
    input  logic            reset_n_in,
    pc_sequencer_if.master  bus
);

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  instr_pc;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               req;
    logic               flush;
    logic               redirect;

    assign redirect = bus.pc_ctl_0_in | bus.pc_ctl_1_in;

    // req and instr_valid are registered alongside the state so they track FETCH / HOLD exactly
    always_ff @(posedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            req         <= 1'b0;
            flush       <= 1'b0;
        end else begin
            flush <= redirect;
            if (redirect) begin
                pc <= bus.target_in;
            end
            case (state)
                BOOT: begin
                    state <= FETCH;
                    req   <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ready_in) begin
                        state <= redirect ? DROP : WAIT;
                        req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        state <= bus.imem_valid_in ? FETCH : DROP;
                        req   <= bus.imem_valid_in;
                    end else if (bus.imem_valid_in) begin
                        instr       <= bus.imem_data_in;
                        instr_pc    <= pc;
                        pc          <= pc + 1'b1;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect || bus.instr_ready_in) begin
                        state       <= FETCH;
                        instr_valid <= 1'b0;
                        req         <= 1'b1;
                    end
                end
                DROP: begin
                    if (bus.imem_valid_in) begin
                        state <= FETCH;
                        req   <= 1'b1;
                    end
                end
                default: begin
                    state       <= BOOT;
                    req         <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Address is gated so every output reads low while booting
    assign bus.imem_req_out    = req;
    assign bus.imem_addr_out   = req ? pc : '0;
    assign bus.instr_valid_out = instr_valid;
    assign bus.instr_out       = instr;
    assign bus.instr_pc_out    = instr_pc;
    assign bus.flush_out       = flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_sequencer_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    pc_sequencer #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h3000)) dut (
        .clka       (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fetch/hold bookkeeping in transaction terms
    logic        m_boot, m_out, m_sq, m_held, m_flush;
    logic [15:0] m_pc, m_hpc, m_hdata;
    // Instruction memory model
    logic        mem_pend;
    int          mem_cnt;
    logic [15:0] mem_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h3000) return 16'h1234;
        return (a ^ 16'h5A5A) + 16'h0101;
    endfunction

    function automatic logic exp_req();
        return !m_boot && !m_out && !m_held;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_out = 1'b0; m_sq = 1'b0; m_held = 1'b0; m_flush = 1'b0;
        m_pc = 16'h3000; m_hpc = '0; m_hdata = '0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
    endtask

    task automatic drive_idle();
        bus.pc_ctl_0_in = 0; bus.pc_ctl_1_in = 0; bus.target_in = '0;
        bus.imem_ready_in = 0; bus.imem_valid_in = 0; bus.imem_data_in = '0;
        bus.instr_ready_in = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},    16'(bus.imem_req_out), 16'h0);
        check({tag, "_addr"},   bus.imem_addr_out, 16'h0);
        check({tag, "_ivalid"}, 16'(bus.instr_valid_out), 16'h0);
        check({tag, "_instr"},  bus.instr_out, 16'h0);
        check({tag, "_ipc"},    bus.instr_pc_out, 16'h0);
        check({tag, "_flush"},  16'(bus.flush_out), 16'h0);
    endtask

    task automatic model_step(input logic r, input logic [15:0] tgt, input logic mrdy,
                              input logic v, input logic drdy);
        m_flush = r;
        if (m_boot) begin
            m_boot = 1'b0;
            if (r) m_pc = tgt;
        end else if (m_out) begin
            if (v) begin
                m_out = 1'b0;
                if (!m_sq && !r) begin
                    m_held  = 1'b1;
                    m_hpc   = m_pc;
                    m_hdata = mem_word(m_pc);
                    m_pc    = m_pc + 16'h1;
                end
            end else if (r) begin
                m_sq = 1'b1;
            end
            if (r) m_pc = tgt;
        end else if (m_held) begin
            if (r) begin
                m_held = 1'b0;
                m_pc   = tgt;
            end else if (drdy) begin
                m_held = 1'b0;
            end
        end else begin
            if (mrdy) begin
                m_out = 1'b1;
                m_sq  = r;
            end
            if (r) m_pc = tgt;
        end
    endtask

    // Called at a falling edge: check outputs, drive next inputs, advance model, wait one cycle
    task automatic cycle(input logic c0, input logic c1, input logic [15:0] tgt,
                         input logic mrdy, input logic drdy, input int lat);
        logic v, acc;
        check("req", 16'(bus.imem_req_out), 16'(exp_req()));
        if (exp_req()) check("addr", bus.imem_addr_out, m_pc);
        if (m_boot)    check("boot_addr", bus.imem_addr_out, 16'h0);
        check("ivalid", 16'(bus.instr_valid_out), 16'(m_held));
        if (m_held) begin
            check("instr", bus.instr_out, m_hdata);
            check("ipc", bus.instr_pc_out, m_hpc);
        end
        check("flush", 16'(bus.flush_out), 16'(m_flush));

        v = mem_pend && (mem_cnt == 0);
        if (mem_pend && mem_cnt != 0) mem_cnt--;
        bus.pc_ctl_0_in    = c0;
        bus.pc_ctl_1_in    = c1;
        bus.target_in      = tgt;
        bus.imem_ready_in  = mrdy;
        bus.imem_valid_in  = v;
        bus.imem_data_in   = v ? mem_word(mem_addr) : 16'($urandom);
        bus.instr_ready_in = drdy;
        acc = bus.imem_req_out && mrdy;
        model_step(c0 | c1, tgt, mrdy, v, drdy);
        if (v) mem_pend = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = lat - 1;
            mem_addr = bus.imem_addr_out;
        end
        @(negedge clk);
    endtask

    function automatic logic cond(input int k);
        case (k)
            0:       return m_held;
            1:       return m_out && !m_sq;
            default: return exp_req();
        endcase
    endfunction

    task automatic run_until(input int k, input logic drdy, input int lat, input string tag);
        for (int i = 0; i < 20 && !cond(k); i++) cycle(0, 0, 16'h0, 1, drdy, lat);
        if (!cond(k)) check({tag, "_timeout"}, 16'h0, 16'h1);
    endtask

    task automatic run_plain(input int n, input logic drdy, input int lat);
        for (int i = 0; i < n; i++) cycle(0, 0, 16'h0, 1, drdy, lat);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // Zero-wait memory, decoder always ready: 0x3000 -> 0x1234, then 0x3001 ...
        run_plain(12, 1, 1);

        // Branch in HOLD with decoder ready in the same cycle
        run_until(0, 0, 1, "hold");
        cycle(1, 0, 16'h3050, 0, 1, 1);
        run_plain(6, 1, 1);

        // Redirect in WAIT, response arrives later and must be dropped
        run_until(1, 1, 4, "wait");
        cycle(1, 0, 16'h4000, 0, 1, 4);
        run_plain(10, 1, 1);

        // Redirect coinciding with the memory accepting a fetch
        run_until(2, 1, 2, "fetch");
        cycle(0, 1, 16'h5a00, 1, 1, 2);
        run_plain(10, 1, 1);

        // Decoder stall in HOLD
        run_until(0, 0, 1, "stall");
        run_plain(5, 0, 1);
        run_plain(4, 1, 1);

        // Wraparound of the PC
        run_until(2, 1, 1, "wrap");
        cycle(0, 1, 16'hFFFF, 0, 1, 1);
        run_plain(10, 1, 1);

        // Reset asserted while a fetch is outstanding
        run_until(1, 1, 3, "rstwait");
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_plain(6, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, c0, c1;
            logic [15:0] tgt;
            r   = ($urandom_range(7) == 0) && !m_boot;
            c0  = r && ($urandom_range(1) == 1);
            c1  = r && (!c0 || ($urandom_range(1) == 1));
            tgt = ($urandom_range(15) == 0) ? 16'hFFFF : 16'($urandom);
            cycle(c0, c1, tgt, $urandom_range(3) != 0, $urandom_range(1) == 1,
                  int'($urandom_range(4, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and instruction-fetch sequencer sitting directly downstream of the condition-code/branch-decision stage. It consumes the branch-taken decision (`pc_ctl_0`) and the decoder's unconditional-jump request. It maintains the PC, issues one-outstanding-request fetches to instruction memory, and presents each fetched instruction with its PC to the decoder over a valid/ready handshake. Redirects squash any in-flight or held instruction.

## Interface
- `ADDR_W`, 16: PC / instruction address width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 16'h3000: PC value after reset.
- `clka` in 1: sole clock; all state is updated on the rising edge.
- `reset_n_in` in 1: asynchronous, active-low reset.
- `pc_ctl_0_in` in 1: conditional branch taken, from the branch-decision FSM.
- `pc_ctl_1_in` in 1: unconditional jump (JMP/JSR/TRAP), from the decoder.
- `target_in` in ADDR_W: redirect target; sampled when either ctl input is high.
- `imem_req_out` out 1: fetch request valid.
- `imem_addr_out` out ADDR_W: fetch address, equal to the current PC.
- `imem_ready_in` in 1: memory accepts the request this cycle.
- `imem_valid_in` in 1: response data valid.
- `imem_data_in` in INSTR_W: response data.
- `instr_valid_out` out 1: held instruction valid.
- `instr_out` out INSTR_W: held instruction.
- `instr_pc_out` out ADDR_W: PC of the held instruction.
- `instr_ready_in` in 1: decoder consumes the instruction.
- `flush_out` out 1: registered one-cycle pulse, high the cycle after any redirect is taken.

## Operation
- `redirect = pc_ctl_0_in | pc_ctl_1_in`. Redirect has priority over every other event in every state.
- On any redirect, `pc <= target_in`. When several redirects occur, the latest one wins.
- States: BOOT, FETCH, WAIT, HOLD, DROP.
- BOOT: all outputs are low. Unconditionally moves to FETCH on the next cycle.
- FETCH: `imem_req_out=1`, `imem_addr_out=pc`.
  - Redirect with `imem_ready_in` high: go to DROP, because the accepted request is stale.
  - Redirect with `imem_ready_in` low: stay in FETCH.
  - No redirect, `imem_ready_in` high: go to WAIT.
- WAIT: waits for `imem_valid_in`.
  - `imem_valid_in` without redirect: capture `instr_out <= imem_data_in`, set `instr_pc_out <= pc`, `pc <= pc+1`, go to HOLD.
  - Redirect with `imem_valid_in` in the same cycle: discard the data, go to FETCH.
  - Redirect without `imem_valid_in`: go to DROP.
- HOLD: `instr_valid_out=1`; `instr_out` and `instr_pc_out` stay stable.
  - Redirect: drop the held instruction, go to FETCH. This applies even if `instr_ready_in` is high.
  - `instr_ready_in` without redirect: go to FETCH.
- DROP: wait for `imem_valid_in`, discard the data, then go to FETCH. A redirect in DROP only updates `pc`.
- Only one memory request is ever outstanding. `imem_req_out` is low in every state except FETCH.
- PC arithmetic is modulo 2^ADDR_W: `16'hFFFF + 1 = 16'h0000`. The target is taken verbatim.

## Timing
- Reset values: state BOOT, `pc=RESET_PC`, `instr_out=0`, `instr_pc_out=0`, `instr_valid_out=0`, `imem_req_out=0`, `flush_out=0`.
- After reset is released, the first request (`imem_addr_out=RESET_PC`) appears in the 2nd cycle.
- Reset asserted mid-operation: all state is cleared immediately. Instruction memory shares the same reset, so no stale response arrives afterwards.
- Redirect at cycle t:
  - `flush_out` is high during t+1.
  - If the next state is FETCH, `imem_addr_out=target` at t+1.
- Zero-wait memory case (ready in FETCH, valid the following cycle, ready in HOLD): one instruction per 3 cycles.
- `instr_valid_out` rises the cycle after `imem_valid_in` is sampled in WAIT.

## Structure
- Shared package `pc_seq_pkg`: state enum (BOOT, FETCH, WAIT, HOLD, DROP), the default `RESET_PC`, and `INSTR_W`.
- Single flat module. No sub-module is natural; the PC register and incrementer stay inline.

## Test plan
- Reset release with memory always ready and 1-cycle latency, memory returns `16'h1234` for address `3000`:
  - `imem_addr_out`: `3000`, then `3001`.
  - `instr_out=16'h1234`, `instr_pc_out=3000`.
  - One instruction delivered every 3 cycles.
- Branch taken in HOLD, `target_in=16'h3050`, with `instr_ready_in=1` in the same cycle:
  - The held instruction is not counted as consumed.
  - `flush_out` pulses once.
  - The next `imem_addr_out` is `3050`.
- Redirect in WAIT (to `4000`) with the response arriving 3 cycles later:
  - The response is discarded.
  - `instr_valid_out` stays 0.
  - A fetch of `4000` follows the response.
- Redirect coinciding with `imem_ready_in` in FETCH at PC `3002`:
  - The state goes to DROP.
  - Data for `3002` is never presented.
  - The next fetch is the target address.
- Decoder stalls (`instr_ready_in=0` for 5 cycles) in HOLD:
  - `instr_out` and `instr_pc_out` stay stable.
  - `imem_req_out` stays 0 throughout the stall.
- PC at `16'hFFFF` fetched: the next fetch is `16'h0000`. Asserting reset mid-WAIT returns all outputs to their reset values immediately.
